// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scan
//                controller: FSM state encoding, column reset pattern and
//                the {row, col} -> hex key map.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } scan_state_t;

    // Column 0 is driven low first after reset.
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row[1:0], col[1:0]}; reflects the physical keypad legend.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Index of the lowest-numbered bit that is low; used both to pick the
    // winning row among simultaneous presses and to encode the active column.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running divider producing a single-cycle tick every
//                TICK_DIV clocks (counter wraps at TICK_DIV-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap to zero on the terminal value.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_ctrl
//  Description : 4x4 matrix keypad scanner. Rotates an active-low column
//                drive on each scan tick, synchronizes and debounces the row
//                returns, and emits one registered hex key event per press.
//                Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 10000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    // One counter serves both debounce and auto-repeat; sized for the larger.
    localparam int CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS);
`endif

    logic             tick;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_sync_q;
    scan_state_t      state_q,     state_d;
    logic [3:0]       cols_q,      cols_d;
    logic [1:0]       row_idx_q,   row_idx_d;
    logic [1:0]       col_idx_q,   col_idx_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic             key_held_q,  key_held_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             row_low;
    logic [3:0]       cols_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer; idle (all released) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    assign cnt_inc   = cnt_q + 1'b1;
    assign row_low   = ~rows_sync_q[row_idx_q];
    assign cols_next = {cols_q[2:0], cols_q[3]};

    // Scan/debounce FSM: every transition is gated by the scan tick.
    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rows_sync_q == 4'b1111) begin
                        cols_d = cols_next;
                    end else begin
                        row_idx_d = low_index(rows_sync_q);
                        col_idx_d = low_index(cols_q);
                        cnt_d     = '0;
                        state_d   = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            key_valid_d = 1'b1;
                            key_code_d  = KEYMAP[{row_idx_q, col_idx_q}];
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other rows are ignored.
                    if (!row_low) begin
                        cnt_d   = '0;
                        state_d = DEB_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == REP_LAST) begin
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end
`endif
                end
                DEB_RELEASE: begin
                    if (!row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            key_held_d = 1'b0;
                            cols_d     = cols_next;
                            state_d    = SCAN;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            cols_q      <= COL_RESET;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cols      = cols_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_ctrl
//  Description : Self-checking bench for keypad_scan_ctrl with a physical
//                keypad model (pressed keys pull rows low only while their
//                column is driven) and a tick-level behavioural reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 2;
    localparam int REP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] pressed;   // bit index = row*4 + col

    int n_pass = 0;
    int n_total = 0;
    int n_kv = 0;
    int base;

    logic [3:0] keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    function automatic logic [3:0] rows_from(input logic [15:0] p, input int col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) if (p[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    // Physical keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++) if (cols[c] === 1'b0) rows = rows & rows_from(pressed, c);
    end

    // ---------------- behavioural reference (tick-level) ----------------
    int         m_cyc, m_col, m_phase, m_row, m_streak, m_rep;
    logic       m_held, m_kv;
    logic [3:0] m_code, m_h1, m_h2, m_s, m_cols;
    bit         m_found;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_col = 0; m_phase = 0; m_row = 0; m_streak = 0; m_rep = 0;
            m_held = 1'b0; m_kv = 1'b0; m_code = 4'h0; m_h1 = 4'hF; m_h2 = 4'hF;
        end else begin
            m_s  = m_h2;                         // rows seen two clocks ago
            m_h2 = m_h1;
            m_h1 = rows_from(pressed, m_col);
            m_kv = 1'b0;
            if (m_cyc % TD == TD - 1) begin
                case (m_phase)
                    0: if (m_s == 4'hF) m_col = (m_col + 1) % 4;
                       else begin
                           m_found = 0;
                           for (int i = 0; i < 4; i++)
                               if (!m_found && !m_s[i]) begin m_row = i; m_found = 1; end
                           m_streak = 0; m_phase = 1;
                       end
                    1: if (!m_s[m_row]) begin
                           m_streak++;
                           if (m_streak == DEB) begin
                               m_kv = 1'b1; m_code = keys[m_row*4 + m_col];
                               m_held = 1'b1; m_phase = 2; m_rep = 0;
                           end
                       end else m_phase = 0;
                    2: if (m_s[m_row]) begin m_streak = 0; m_phase = 3; end
`ifdef KEYPAD_AUTOREPEAT_EN
                       else begin
                           m_rep++;
                           if (m_rep == REP) begin m_kv = 1'b1; m_rep = 0; end
                       end
`endif
                    default: if (m_s[m_row]) begin
                           m_streak++;
                           if (m_streak == DEB) begin
                               m_held = 1'b0; m_col = (m_col + 1) % 4; m_phase = 0;
                           end
                       end else begin m_phase = 2; m_rep = 0; end
                endcase
            end
            m_cyc++;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            m_cols = 4'hF & ~(4'h1 << m_col);
            check("model_cols", cols, m_cols);
            check("model_key_valid", {3'b000, key_valid}, {3'b000, m_kv});
            check("model_key_code", key_code, m_code);
            check("model_key_held", {3'b000, key_held}, {3'b000, m_held});
            if (key_valid === 1'b1) n_kv++;
        end
    end

    // Advance n scan ticks, landing on the falling edge after the last tick.
    task automatic ticks(input int n);
        repeat (4 * n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cols(input logic [3:0] target);
        logic [3:0] prev;
        bit ok;
        ok = 0;
        prev = cols;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk); #1;
            if (cols == target && prev != target) ok = 1;
            prev = cols;
        end
        if (!ok) check_int("wait_cols_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_rotation();
        logic [3:0] seq [4];
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        for (int i = 0; i < 4; i++) begin
            repeat (TD) @(posedge clk);
            #1 check("rotate_cols", cols, seq[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b0;
        pressed = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cols", cols, 4'b1110);
        check("reset_key_valid", {3'b000, key_valid}, 4'h0);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_held", {3'b000, key_held}, 4'h0);
        reset = 1'b0;
        check_rotation();

        // Clean press of '5' (row 1, column 1).
        wait_cols(4'b1101);
        base = n_kv;
        pressed[1*4+1] = 1'b1;
        ticks(4);
        check_int("press5_pulses", n_kv - base, 1);
        check("press5_code", key_code, 4'h5);
        check("press5_held", {3'b000, key_held}, 4'h1);
        check("press5_cols_frozen", cols, 4'b1101);

        // Release bounce: high for one tick only.
        pressed[1*4+1] = 1'b0;
        ticks(1);
        pressed[1*4+1] = 1'b1;
        ticks(2);
        check("rel_bounce_held", {3'b000, key_held}, 4'h1);
        check("rel_bounce_cols", cols, 4'b1101);
        check_int("rel_bounce_pulses", n_kv - base, 1);

        // Real release.
        pressed[1*4+1] = 1'b0;
        ticks(3);
        check("release_held", {3'b000, key_held}, 4'h0);
        check("release_cols", cols, 4'b1011);

        // Press bounce on '9': one tick low, then scanning resumes.
        base = n_kv;
        pressed[2*4+2] = 1'b1;
        ticks(1);
        pressed[2*4+2] = 1'b0;
        ticks(2);
        check_int("bounce_pulses", n_kv - base, 0);
        check("bounce_held", {3'b000, key_held}, 4'h0);
        check("bounce_cols", cols, 4'b0111);

        // Two keys in column 3: 'A' (row 0) wins over 'C' (row 2).
        base = n_kv;
        pressed[0*4+3] = 1'b1;
        pressed[2*4+3] = 1'b1;
        ticks(4);
        check("two_key_code", key_code, 4'hA);
        check("two_key_held", {3'b000, key_held}, 4'h1);
        check_int("two_key_pulses", n_kv - base, 1);
        pressed[0*4+3] = 1'b0;
        ticks(3);
        check("two_key_rel_held", {3'b000, key_held}, 4'h0);
        check("two_key_rel_cols", cols, 4'b1110);
        check("two_key_rel_code", key_code, 4'hA);
        ticks(7);
        check("rescan_code", key_code, 4'hC);
        check("rescan_held", {3'b000, key_held}, 4'h1);
        check_int("rescan_pulses", n_kv - base, 2);
        pressed[2*4+3] = 1'b0;
        ticks(4);
        check("c_release_held", {3'b000, key_held}, 4'h0);

        // Hold 'F' for 10 ticks after acceptance.
        base = n_kv;
        pressed[3*4+2] = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (key_held === 1'b1) ok = 1;
        end
        if (!ok) check_int("wait_held_timeout", 0, 1);
        @(negedge clk);
        ticks(10);
        @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
        check_int("hold_f_pulses", n_kv - base, 4);
`else
        check_int("hold_f_pulses", n_kv - base, 1);
`endif
        check("hold_f_code", key_code, 4'hF);

        // Asynchronous reset in the middle of a hold, away from any clock edge.
        #1 reset = 1'b1;
        pressed = '0;
        #1;
        check("midreset_cols", cols, 4'b1110);
        check("midreset_key_valid", {3'b000, key_valid}, 4'h0);
        check("midreset_key_held", {3'b000, key_held}, 4'h0);
        check("midreset_key_code", key_code, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        check_rotation();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
